serial_adder: RTL and testbench
===============================

# serial_adder

Multi-cycle, parametrised ripple adder built around a DIGIT-bit full-adder slice. Each clock it adds one DIGIT-bit chunk of two WIDTH-bit operands, LSB chunk first, with the carry held in a flop between chunks. It is the sequential successor to the single-bit full adder. It gives area-constrained datapaths an N-bit add with a start/done handshake, a carry-out and a signed-overflow flag.

## Interface
- WIDTH, 8, operand and sum width. Must be ≥1 and an integer multiple of DIGIT.
- DIGIT, 1, bits added per cycle. Must be ≥1 and ≤WIDTH. N = WIDTH/DIGIT chunks.
- clk  in  1  single clock. All state changes on its rising edge.
- rst  in  1  synchronous, active-high reset. Sampled on the rising edge of clk.
- start  in  1  request. Accepted only in IDLE or DONE.
- a  in  WIDTH  operand A. Sampled on the accepting edge only.
- b  in  WIDTH  operand B. Sampled on the accepting edge only.
- cin  in  1  carry-in. Sampled on the accepting edge only.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse marking that sum, cout and ovf are newly valid.
- sum  out  WIDTH  result, (a+b+cin) mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE → RUN when start=1:
  - capture a, b and cin into internal operand registers and the carry flop;
  - set chunk counter = 0.
- RUN, each cycle:
  - add chunk[counter] of A and B plus the carry flop;
  - write the DIGIT-bit result into the internal accumulator at the same chunk position;
  - update the carry flop and increment the counter.
- RUN → DONE on the cycle that processes chunk N-1:
  - load sum from the accumulator, cout from the final carry, and ovf from the carry into and out of bit WIDTH-1.
- DONE → RUN if start=1, with capture as from IDLE (back-to-back operation). Otherwise DONE → IDLE.
- start is ignored in RUN. A running operation is never restarted or aborted except by rst.
- sum, cout and ovf are registered and change only on entry to DONE. They hold their last result through IDLE and through the following RUN.
- Operand changes after the accepting edge have no effect on the current operation.
- Arithmetic is unsigned modulo 2^WIDTH. cout and ovf are both produced every operation, so the caller picks the unsigned or signed interpretation.
- WIDTH=DIGIT (N=1) is legal: RUN lasts one cycle.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled in IDLE or DONE.
- busy=1 in cycles 1..N.
- done=1 in cycle N+1 only, with sum, cout and ovf valid from cycle N+1.
- Latency from start to done is N+1 cycles. Maximum throughput is one result per N+1 cycles, achieved by asserting start in each DONE cycle.
- Default configuration (WIDTH=8, DIGIT=1): done in cycle 9.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state IDLE, counter 0, carry flop 0.
- rst during RUN or DONE:
  - the next cycle is IDLE with all outputs at reset values;
  - no done pulse is produced for the aborted operation.
- rst and start high on the same edge: rst wins and start is dropped.
- The counter never wraps past N-1.

## Test plan
- WIDTH=1, DIGIT=1, all 8 combinations of a, b, cin, each started from IDLE → sum and cout match the full-adder truth table (e.g. 1+1+1 → sum=1, cout=1), with done exactly 2 cycles after start.
- Defaults, a=8'h5A, b=8'h3C, cin=0 → done in cycle 9 with sum=8'h96, cout=0, ovf=1. busy high in cycles 1–8 only.
- Defaults, a=8'hFF, b=8'h00, cin=1 → sum=8'h00, cout=1, ovf=0. Repeat with WIDTH=8, DIGIT=4, a=8'h80, b=8'h80, cin=0 → done in cycle 3, sum=8'h00, cout=1, ovf=1.
- start held high continuously with operands changing every cycle → only the operands present in cycle 0 and in each DONE cycle are used. Results arrive every 9 cycles and other start pulses are ignored.
- rst asserted in cycle 4 of an operation → busy=0, sum=0 and no done pulse. A new start afterwards with a=8'h01, b=8'h01 → sum=8'h02 in cycle 9.
- Back-to-back sums: after 8'h10+8'h20, issue 8'h7F+8'h01 with start in the DONE cycle → sum holds 8'h30 until the second done, then sum=8'h80 and ovf=1.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle ripple adder, one DIGIT-bit chunk per clock, LSB chunk first.
// Ports: clk, rst (sync, active-high), start/a/b/cin in; busy, done, sum, cout, ovf out.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] a_chunk;
    logic [DIGIT-1:0] b_chunk;
    logic [DIGIT:0]   slice;
    logic             c_msb;
    logic             last;
    logic [WIDTH-1:0] acc_nxt;

    // Operands shift right each RUN cycle, so the active chunk is
    // always the low DIGIT bits.
    assign a_chunk = op_a[DIGIT-1:0];
    assign b_chunk = op_b[DIGIT-1:0];

    assign slice = {1'b0, a_chunk}
                 + {1'b0, b_chunk}
                 + {{DIGIT{1'b0}}, carry};

    // Carry into the top bit of the chunk, recovered from a^b^s.
    assign c_msb = a_chunk[DIGIT-1]
                 ^ b_chunk[DIGIT-1]
                 ^ slice[DIGIT-1];

    // Result chunks enter at the top and shift down; after N
    // cycles chunk 0 sits at bit 0.
    assign acc_nxt = (acc >> DIGIT)
                   | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));

    assign last = (cnt == CW'(N - 1));

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    op_a  <= op_a >> DIGIT;
                    op_b  <= op_b >> DIGIT;
                    acc   <= acc_nxt;
                    carry <= slice[DIGIT];
                    if (last) begin
                        sum   <= acc_nxt;
                        cout  <= slice[DIGIT];
                        ovf   <= c_msb ^ slice[DIGIT];
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table vectors, directed sequences and random ops
// on three serial_adder configs (8/1, 8/4, 1/1) against an arithmetic model.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       st[3];
    logic       ic[3];
    logic [7:0] ia[2];
    logic [7:0] ib[2];
    logic       w1_a;
    logic       w1_b;
    logic       busy_o[3];
    logic       done_o[3];
    logic       cout_o[3];
    logic       ovf_o[3];
    logic [7:0] sum_o[3];
    logic [7:0] sum_m;
    logic [7:0] sum_d4;
    logic       w1_sum;

    assign sum_o[0] = sum_m;
    assign sum_o[1] = sum_d4;
    assign sum_o[2] = {7'b0, w1_sum};

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_main (
        .clk(clk), .rst(rst), .start(st[0]),
        .a(ia[0]), .b(ib[0]), .cin(ic[0]),
        .busy(busy_o[0]), .done(done_o[0]),
        .sum(sum_m), .cout(cout_o[0]), .ovf(ovf_o[0])
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(st[1]),
        .a(ia[1]), .b(ib[1]), .cin(ic[1]),
        .busy(busy_o[1]), .done(done_o[1]),
        .sum(sum_d4), .cout(cout_o[1]), .ovf(ovf_o[1])
    );

    serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1 (
        .clk(clk), .rst(rst), .start(st[2]),
        .a(w1_a), .b(w1_b), .cin(ic[2]),
        .busy(busy_o[2]), .done(done_o[2]),
        .sum(w1_sum), .cout(cout_o[2]), .ovf(ovf_o[2])
    );

    typedef struct {
        int         k;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t       tbl[11];
    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] last_sum[3];

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int k, logic s, logic [7:0] a, logic [7:0] b, logic c);
        st[k] = s;
        ic[k] = c;
        if (k == 2) begin
            w1_a = a[0];
            w1_b = b[0];
        end else begin
            ia[k] = a;
            ib[k] = b;
        end
    endtask

    // Plain arithmetic reference: full-width sum, then sign rule for ovf.
    function automatic void ref_add(int w, logic [7:0] a, logic [7:0] b,
                                    logic c, output logic [7:0] s,
                                    output logic co, output logic ov);
        int unsigned m, t;
        logic sa, sb, sr;
        m  = (32'd1 << w) - 1;
        t  = (a & m) + (b & m) + c;
        s  = 8'(t & m);
        co = t[w];
        sa = a[w-1];
        sb = b[w-1];
        sr = s[w-1];
        ov = (sa == sb) && (sr != sa);
    endfunction

    task automatic op(int k, logic [7:0] a, logic [7:0] b, logic c,
                      logic hold, string tag, logic use_tbl,
                      logic [7:0] es, logic eco, logic eov);
        int n, w;
        logic [7:0] ms;
        logic mco, mov, hold_ok;
        logic [9:0] bm, dm;
        n = (k == 0) ? 8 : (k == 1) ? 2 : 1;
        w = (k == 2) ? 1 : 8;
        ref_add(w, a, b, c, ms, mco, mov);
        drive(k, 1'b1, a, b, c);
        bm = '0;
        dm = '0;
        hold_ok = 1'b1;
        for (int cyc = 1; cyc <= n + 1; cyc++) begin
            tick();
            bm[cyc] = busy_o[k];
            dm[cyc] = done_o[k];
            if (cyc <= n && sum_o[k] !== last_sum[k]) hold_ok = 1'b0;
            drive(k, hold, 8'($urandom), 8'($urandom), 1'($urandom));
        end
        check($sformatf("%s busy", tag), 32'(bm),
              32'(((1 << (n + 1)) - 1) & ~1));
        check($sformatf("%s done", tag), 32'(dm), 32'(1 << (n + 1)));
        check($sformatf("%s hold", tag), 32'(hold_ok), 32'd1);
        check($sformatf("%s sum", tag), 32'(sum_o[k]), 32'(ms));
        check($sformatf("%s cout", tag), 32'(cout_o[k]), 32'(mco));
        check($sformatf("%s ovf", tag), 32'(ovf_o[k]), 32'(mov));
        if (use_tbl) begin
            check($sformatf("%s tsum", tag), 32'(sum_o[k]), 32'(es));
            check($sformatf("%s tcout", tag), 32'(cout_o[k]), 32'(eco));
            check($sformatf("%s tovf", tag), 32'(ovf_o[k]), 32'(eov));
        end
        last_sum[k] = ms;
    endtask

    initial begin
        logic seen;
        tbl[0]  = '{2, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{2, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1};
        tbl[2]  = '{2, 8'h00, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0};
        tbl[3]  = '{2, 8'h00, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[4]  = '{2, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0};
        tbl[5]  = '{2, 8'h01, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[6]  = '{2, 8'h01, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[7]  = '{2, 8'h01, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
        tbl[8]  = '{0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        tbl[9]  = '{0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[10] = '{1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(k, 1'b0, 8'h00, 8'h00, 1'b0);
            last_sum[k] = 8'h00;
        end
        tick();
        tick();
        rst = 1'b0;

        check("rst busy", 32'(busy_o[0]), 32'd0);
        check("rst done", 32'(done_o[0]), 32'd0);
        check("rst sum", 32'(sum_o[0]), 32'd0);
        check("rst cout", 32'(cout_o[0]), 32'd0);
        check("rst ovf", 32'(ovf_o[0]), 32'd0);

        for (int i = 0; i < 11; i++) begin
            op(tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].c, 1'b0,
               $sformatf("tbl%0d", i), 1'b1, tbl[i].s, tbl[i].co, tbl[i].ov);
            tick();
        end

        // back-to-back: second start lands in the DONE cycle
        op(0, 8'h10, 8'h20, 1'b0, 1'b0, "b2b1", 1'b1, 8'h30, 1'b0, 1'b0);
        op(0, 8'h7F, 8'h01, 1'b0, 1'b0, "b2b2", 1'b1, 8'h80, 1'b0, 1'b1);
        tick();

        // start held high, operands churning every cycle
        op(0, 8'hC3, 8'h5D, 1'b1, 1'b1, "hold1", 1'b0, 8'h00, 1'b0, 1'b0);
        op(0, 8'h41, 8'h3F, 1'b0, 1'b1, "hold2", 1'b0, 8'h00, 1'b0, 1'b0);
        op(0, 8'h99, 8'hE7, 1'b1, 1'b1, "hold3", 1'b0, 8'h00, 1'b0, 1'b0);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();

        // reset in cycle 4, with start also high on the reset edge
        drive(0, 1'b1, 8'h33, 8'h44, 1'b0);
        tick();
        drive(0, 1'b0, 8'hAA, 8'hAA, 1'b1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        drive(0, 1'b1, 8'h11, 8'h22, 1'b0);
        tick();
        rst = 1'b0;
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        check("abort busy", 32'(busy_o[0]), 32'd0);
        check("abort done", 32'(done_o[0]), 32'd0);
        check("abort sum", 32'(sum_o[0]), 32'd0);
        check("abort cout", 32'(cout_o[0]), 32'd0);
        check("abort ovf", 32'(ovf_o[0]), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done_o[0] || busy_o[0]) seen = 1'b1;
        end
        check("abort quiet", 32'(seen), 32'd0);
        for (int k = 0; k < 3; k++) last_sum[k] = 8'h00;
        op(0, 8'h01, 8'h01, 1'b0, 1'b0, "post", 1'b1, 8'h02, 1'b0, 1'b0);
        tick();

        // randomized ops, mixing idle gaps, back-to-back and held start
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 15; i++) begin
                logic hs;
                hs = (i == 14) ? 1'b0 : 1'($urandom);
                op(k, 8'($urandom), 8'($urandom), 1'($urandom), hs,
                   $sformatf("rnd%0d_%0d", k, i), 1'b0, 8'h00, 1'b0, 1'b0);
                if (!hs && 1'($urandom)) tick();
            end
            drive(k, 1'b0, 8'h00, 8'h00, 1'b0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
